// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl: pipeline stall/flush controller covering load-use, branch
// redirect and data-memory wait with a timeout trap.
// Optional: HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
// Revision: 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_timeout_err,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_REDIRECT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  localparam logic [7:0] c_mem_timeout = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_pending;
  logic       w_pending_nxt;
  logic       r_err;
  logic       w_err_nxt;

  logic       w_load_use;
  logic       w_pc_stall;
  logic       w_if_id_stall;
  logic       w_id_ex_stall;
  logic       w_ex_mem_stall;
  logic       w_if_id_flush;
  logic       w_id_ex_flush;

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 8'd0;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_pending_nxt  = r_pending;
    w_err_nxt      = r_err;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;

    case (r_state)
      S_RUN: begin
        // A pending memory access freezes everything; the branch stays in EX
        // and is seen again once MEM_WAIT is entered.
        if (mem_req && !mem_ready) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_wait_cnt_nxt = 8'd1;
          w_next_state   = S_MEM_WAIT;
        end else if (ex_branch_taken) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (ex_branch_taken) begin
          w_pending_nxt = 1'b1;
        end
        if (mem_ready) begin
          w_wait_cnt_nxt = 8'd0;
          w_next_state   = (r_pending || ex_branch_taken) ? S_REDIRECT : S_RUN;
        end else begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          if (r_wait_cnt == c_mem_timeout) begin
            w_next_state = S_ERROR;
            w_err_nxt    = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
      end

      S_REDIRECT: begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
        w_pending_nxt = 1'b0;
        w_next_state  = S_RUN;
      end

      default: begin
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_stall  = 1'b1;
        w_ex_mem_stall = 1'b1;
        w_err_nxt      = 1'b1;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  assign pc_stall        = rst & w_pc_stall;
  assign if_id_stall     = rst & w_if_id_stall;
  assign id_ex_stall     = rst & w_id_ex_stall;
  assign ex_mem_stall    = rst & w_ex_mem_stall;
  assign if_id_flush     = rst & w_if_id_flush;
  assign id_ex_flush     = rst & w_id_ex_flush;
  assign mem_timeout_err = r_err;
  assign state           = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (pc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (id_ex_flush && (r_flush_events != 32'hFFFF_FFFF)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_timeout_err;
  logic [1:0] state;
  logic       t_pc_stall, t_if_id_stall, t_id_ex_stall, t_ex_mem_stall;
  logic       t_if_id_flush, t_id_ex_flush, t_mem_timeout_err;
  logic [1:0] t_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, t_stall_cycles, t_flush_events;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] ALLST = 6'b111100;
  localparam logic [5:0] LU    = 6'b110001;
  localparam logic [5:0] FL    = 6'b000011;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout_err(mem_timeout_err), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(t_pc_stall), .if_id_stall(t_if_id_stall),
    .id_ex_stall(t_id_ex_stall), .ex_mem_stall(t_ex_mem_stall),
    .if_id_flush(t_if_id_flush), .id_ex_flush(t_id_ex_flush),
    .mem_timeout_err(t_mem_timeout_err), .state(t_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(t_stall_cycles), .flush_events(t_flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_main(input string tag, input logic [5:0] exp_o, input logic [1:0] exp_s);
    chk({tag, ".out"}, {26'd0, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                        if_id_flush, id_ex_flush}, {26'd0, exp_o});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, exp_s});
  endtask

  task automatic chk_to(input string tag, input logic [5:0] exp_o, input logic [1:0] exp_s,
                        input logic exp_err);
    chk({tag, ".out"}, {26'd0, t_pc_stall, t_if_id_stall, t_id_ex_stall, t_ex_mem_stall,
                        t_if_id_flush, t_id_ex_flush}, {26'd0, exp_o});
    chk({tag, ".state"}, {30'd0, t_state}, {30'd0, exp_s});
    chk({tag, ".err"}, {31'd0, t_mem_timeout_err}, {31'd0, exp_err});
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    // Reset held with hazard-provoking inputs: outputs must stay quiet.
    load_use5();
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    step(); #1;
    chk_main("reset_quiet", NONE, 2'd0);
    chk_to("reset_quiet_to", NONE, 2'd0, 1'b0);
    step();
    idle();
    rst = 1'b1;
    #1 chk_main("idle", NONE, 2'd0);

    // Memory wait: 4 stalled cycles then ready.
    step(); mem_req = 1'b1; #1 chk_main("mw_c1", ALLST, 2'd0);
    step(); #1 chk_main("mw_c2", ALLST, 2'd1);
    step(); #1 chk_main("mw_c3", ALLST, 2'd1);
    step(); #1 chk_main("mw_c4", ALLST, 2'd1);
    step(); mem_ready = 1'b1; #1 chk_main("mw_ready", NONE, 2'd1);
    step(); idle(); #1 chk_main("mw_back_run", NONE, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_mw", stall_cycles, 32'd4);
    chk("perf_flush_mw", flush_events, 32'd0);
`endif

    // Load-use on rs1.
    step(); load_use5(); #1 chk_main("lu_rs1", LU, 2'd0);
    step(); idle(); #1 chk_main("lu_after", NONE, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_lu", stall_cycles, 32'd5);
    chk("perf_flush_lu", flush_events, 32'd1);
`endif
    step(); load_use5(); ex_rd = 5'd0; id_rs1 = 5'd0; #1 chk_main("lu_rd0", NONE, 2'd0);
    step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1 chk_main("lu_rs2", LU, 2'd0);
    step(); id_uses_rs2 = 1'b0; #1 chk_main("lu_rs2_unused", NONE, 2'd0);
    step(); idle(); ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1 chk_main("no_load", NONE, 2'd0);

    // Branch beats load-use in the same cycle.
    step(); idle(); load_use5(); ex_branch_taken = 1'b1; #1 chk_main("br_lu", FL, 2'd0);
    step(); idle(); ex_branch_taken = 1'b1; #1 chk_main("br_only", FL, 2'd0);

    // Deferred redirect: branch in MEM_WAIT cycle 2, ready in cycle 5.
    step(); idle(); mem_req = 1'b1; #1 chk_main("dr_c1", ALLST, 2'd0);
    step(); ex_branch_taken = 1'b1; #1 chk_main("dr_c2", ALLST, 2'd1);
    step(); ex_branch_taken = 1'b0; #1 chk_main("dr_c3", ALLST, 2'd1);
    step(); #1 chk_main("dr_c4", ALLST, 2'd1);
    step(); mem_ready = 1'b1; #1 chk_main("dr_c5", NONE, 2'd1);
    step(); idle(); #1 chk_main("dr_c6_redirect", FL, 2'd2);
    step(); #1 chk_main("dr_c7", NONE, 2'd0);

    // Branch arriving in the ready cycle itself also redirects.
    step(); mem_req = 1'b1; #1 chk_main("drr_c1", ALLST, 2'd0);
    step(); mem_ready = 1'b1; ex_branch_taken = 1'b1; #1 chk_main("drr_c2", NONE, 2'd1);
    step(); idle(); #1 chk_main("drr_redirect", FL, 2'd2);
    step(); #1 chk_main("drr_run", NONE, 2'd0);

    // Timeout on the MEM_TIMEOUT=4 instance.
    step(); mem_req = 1'b1; #1 chk_to("to_c1", ALLST, 2'd0, 1'b0);
    step(); #1 chk_to("to_w1", ALLST, 2'd1, 1'b0);
    step(); #1 chk_to("to_w2", ALLST, 2'd1, 1'b0);
    step(); #1 chk_to("to_w3", ALLST, 2'd1, 1'b0);
    step(); #1 chk_to("to_w4", ALLST, 2'd1, 1'b0);
    step(); #1 chk_to("to_error", ALLST, 2'd3, 1'b1);
    chk_main("to_main_waiting", ALLST, 2'd1);
    step(); idle(); mem_ready = 1'b1; #1 chk_to("to_error_hold", ALLST, 2'd3, 1'b1);
    step(); #1 chk_to("to_error_hold2", ALLST, 2'd3, 1'b1);

    // Asynchronous reset away from the clock edge.
    #2 rst = 1'b0;
    #1 chk_to("to_reset_async", NONE, 2'd0, 1'b0);
    chk_main("main_reset_async", NONE, 2'd0);
    step(); idle(); rst = 1'b1;
    step(); #1 chk_to("to_after_reset", NONE, 2'd0, 1'b0);
    chk_main("main_after_reset", NONE, 2'd0);

    // Reset mid-wait discards the pending redirect.
    step(); mem_req = 1'b1; #1 chk_main("rw_c1", ALLST, 2'd0);
    step(); ex_branch_taken = 1'b1; #1 chk_main("rw_c2", ALLST, 2'd1);
    step(); idle(); rst = 1'b0; #1 chk_main("rw_reset", NONE, 2'd0);
    step(); rst = 1'b1; mem_req = 1'b1; mem_ready = 1'b1; #1 chk_main("rw_run", NONE, 2'd0);
    step(); idle(); #1 chk_main("rw_no_redirect", NONE, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before the error trap (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction reads that source.
REQ-006 SHALL have ports ex_rd  input  5  and ex_mem_read  input  1  destination and load flag of the instruction in EX.
REQ-007 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX (redirect).
REQ-008 SHALL have ports mem_req  input  1  and mem_ready  input  1  data-memory access in MEM and its completion.
REQ-009 SHALL have outputs pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  1 each  hold the PC or that pipeline register.
REQ-010 SHALL have outputs if_id_flush, id_ex_flush  1 each  clear that pipeline register to a bubble.
REQ-011 SHALL have outputs mem_timeout_err  1  (sticky) and state  2  (RUN=0, MEM_WAIT=1, REDIRECT=2, ERROR=3).

Function
REQ-012 SHALL drive all stall/flush outputs combinationally from the current state and inputs, so that the pipeline registers act on them at the same edge.
REQ-013 SHALL detect load-use as ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-014 In RUN with mem_req & !mem_ready: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1, flushes = 0, wait_cnt<=1, next state MEM_WAIT.
REQ-015 In RUN otherwise, with ex_branch_taken: if_id_flush = id_ex_flush = 1, no stalls; load-use is ignored in this cycle; state stays RUN.
REQ-016 In RUN otherwise, on load-use: pc_stall = if_id_stall = 1, id_ex_flush = 1 (one bubble), others 0; state stays RUN.
REQ-017 In MEM_WAIT: all four stalls = 1 and flushes = 0; an ex_branch_taken seen in any cycle SHALL set pending_redirect.
REQ-018 In MEM_WAIT with mem_ready=1: all stalls = 0, next state REDIRECT if pending_redirect|ex_branch_taken, else RUN.
REQ-019 In MEM_WAIT with mem_ready=0: wait_cnt increments; when wait_cnt==MEM_TIMEOUT, next state ERROR and mem_timeout_err<=1.
REQ-020 REDIRECT SHALL last exactly one cycle: if_id_flush = id_ex_flush = 1, stalls = 0, pending_redirect<=0, next state RUN.
REQ-021 ERROR SHALL hold all four stalls at 1 and flushes at 0 until reset; mem_timeout_err SHALL stay 1.
REQ-022 The stall and flush of the same register SHALL never both be 1; flush has priority in ID_EX.
REQ-023 wait_cnt SHALL be 8 bits wide and SHALL never wrap (it saturates at MEM_TIMEOUT).

Reset
REQ-024 With rst=0, state=RUN, wait_cnt=0, pending_redirect=0 and mem_timeout_err=0 immediately; all stall/flush outputs SHALL be 0 regardless of other inputs.
REQ-025 Reset mid-MEM_WAIT or in ERROR SHALL abandon the wait and discard the pending redirect; the first edge after release evaluates as RUN.

Configuration
REQ-026 With HAZARD_PERF_CNT_EN defined: the block SHALL add 32-bit outputs stall_cycles and flush_events, both reset to 0.
REQ-027 stall_cycles SHALL increment on each cycle with pc_stall=1; flush_events SHALL increment on each cycle with id_ex_flush=1; both SHALL saturate at 32'hFFFFFFFF.
REQ-028 Without HAZARD_PERF_CNT_EN: no counter ports and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-029 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; ex_rd=0 with the same inputs -> no action.
REQ-030 Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use inputs above -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-031 Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then ready -> all stalls high for 4 cycles, low in the ready cycle, state MEM_WAIT->RUN.
REQ-032 Deferred redirect: ex_branch_taken pulsed in MEM_WAIT cycle 2, ready in cycle 5 -> REDIRECT in cycle 6 with both flushes=1, then RUN.
REQ-033 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> ERROR after 4 wait cycles, mem_timeout_err=1, stalls stuck at 1; rst low -> all outputs 0 at once.
REQ-034 With HAZARD_PERF_CNT_EN: run REQ-031 -> stall_cycles=4, flush_events=0; then REQ-029 -> stall_cycles=5, flush_events=1.
